// File: rtl/xge_pkt_pkg.sv
// Shared types, byte-lane offsets and helpers for the XGE receive packet reader.
package xge_pkt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_GAP  = 2'd2
   } rx_state_e;

   // Low bit of each byte lane; lane 7 carries the first byte on the wire.
   localparam int LANE_W = 8;
   localparam int LANE0  = 0;
   localparam int LANE1  = 8;
   localparam int LANE2  = 16;
   localparam int LANE3  = 24;
   localparam int LANE4  = 32;
   localparam int LANE5  = 40;
   localparam int LANE6  = 48;
   localparam int LANE7  = 56;

   function automatic logic [3:0] mod_to_bytes(input logic [2:0] mod);
      return (mod == 3'd0) ? 4'd8 : {1'b0, mod};
   endfunction

endpackage

// File: rtl/xge_rx_len_acc.sv
// Saturating per-packet byte-length accumulator; sum_o is the length including the current word.
module xge_rx_len_acc #(
   parameter int LEN_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             restart_i,
   input  logic             clear_i,
   input  logic [3:0]       bytes_i,
   output logic [LEN_W-1:0] sum_o
);

   logic [LEN_W-1:0] acc_q;
   logic [LEN_W-1:0] acc_d;

   function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a,
                                                input logic [3:0]       b);
      logic [LEN_W:0] s;
      s = {1'b0, a} + {{(LEN_W-3){1'b0}}, b};
      return s[LEN_W] ? {LEN_W{1'b1}} : s[LEN_W-1:0];
   endfunction

   always_comb begin
      acc_d = acc_q;
      if (restart_i) begin
         acc_d = {{(LEN_W-4){1'b0}}, bytes_i};
      end else begin
         acc_d = sat_add(acc_q, bytes_i);
      end
   end

   assign sum_o = acc_d;

   // The accumulator is emptied once the eop word has been folded in.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= clear_i ? '0 : acc_d;
      end
   end

endmodule

// File: rtl/xge_pkt_rx_reader.sv
// XGE MAC receive reader: drives read enable, forwards words one cycle late,
// measures packet length and counts packets/errors.
module xge_pkt_rx_reader
   import xge_pkt_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk_156m25,
   input  logic              reset_156m25_n,
   input  logic              pkt_rx_avail,
   input  logic              pkt_rx_val,
   input  logic              pkt_rx_sop,
   input  logic              pkt_rx_eop,
   input  logic [2:0]        pkt_rx_mod,
   input  logic              pkt_rx_err,
   input  logic [DATA_W-1:0] pkt_rx_data,
   output logic              pkt_rx_ren,
   input  logic [CNT_W-1:0]  expected_count,
   output logic              out_valid,
   output logic              out_sop,
   output logic              out_eop,
   output logic [2:0]        out_mod,
   output logic [DATA_W-1:0] out_data,
   output logic [LEN_W-1:0]  pkt_len,
   output logic              pkt_len_valid,
   output logic [CNT_W-1:0]  rx_count,
   output logic [CNT_W-1:0]  err_count,
   output logic              proto_err,
   output logic              all_done
);

   rx_state_e         state_q;
   logic              ren_q;
   logic              in_pkt_q;
   logic              out_valid_q;
   logic              out_sop_q;
   logic              out_eop_q;
   logic [2:0]        out_mod_q;
   logic [DATA_W-1:0] out_data_q;
   logic [LEN_W-1:0]  pkt_len_q;
   logic              pkt_len_valid_q;
   logic [CNT_W-1:0]  rx_count_q;
   logic [CNT_W-1:0]  err_count_q;
   logic              proto_err_q;

   logic              rd_word;
   logic              acc_en;
   logic              acc_restart;
   logic [3:0]        acc_bytes;
   logic [LEN_W-1:0]  len_sum;

   assign rd_word     = (state_q == ST_READ) && pkt_rx_val;
   // A stray non-sop word outside a packet only contributes when it closes one.
   assign acc_en      = rd_word && (pkt_rx_sop || in_pkt_q || pkt_rx_eop);
   assign acc_restart = pkt_rx_sop || !in_pkt_q;
   assign acc_bytes   = pkt_rx_eop ? mod_to_bytes(pkt_rx_mod) : 4'd8;

   xge_rx_len_acc #(
      .LEN_W(LEN_W)
   ) u_len_acc (
      .clk_i     (clk_156m25),
      .rst_n_i   (reset_156m25_n),
      .en_i      (acc_en),
      .restart_i (acc_restart),
      .clear_i   (pkt_rx_eop),
      .bytes_i   (acc_bytes),
      .sum_o     (len_sum)
   );

   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         state_q         <= ST_IDLE;
         ren_q           <= 1'b0;
         in_pkt_q        <= 1'b0;
         out_valid_q     <= 1'b0;
         out_sop_q       <= 1'b0;
         out_eop_q       <= 1'b0;
         out_mod_q       <= '0;
         out_data_q      <= '0;
         pkt_len_q       <= '0;
         pkt_len_valid_q <= 1'b0;
         rx_count_q      <= '0;
         err_count_q     <= '0;
         proto_err_q     <= 1'b0;
      end else begin
         out_valid_q     <= 1'b0;
         out_sop_q       <= 1'b0;
         out_eop_q       <= 1'b0;
         pkt_len_valid_q <= 1'b0;
         proto_err_q     <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (pkt_rx_avail) begin
                  ren_q   <= 1'b1;
                  state_q <= ST_READ;
               end
            end
            ST_READ: begin
               if (pkt_rx_val && pkt_rx_eop) begin
                  ren_q   <= 1'b0;
                  state_q <= ST_GAP;
               end
            end
            ST_GAP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               ren_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase

         if (pkt_rx_val && (state_q != ST_READ)) begin
            proto_err_q <= 1'b1;
         end

         if (rd_word) begin
            out_valid_q <= 1'b1;
            out_sop_q   <= pkt_rx_sop;
            out_eop_q   <= pkt_rx_eop;
            out_mod_q   <= pkt_rx_mod;
            out_data_q[LANE0 +: LANE_W] <= pkt_rx_data[LANE0 +: LANE_W];
            out_data_q[LANE1 +: LANE_W] <= pkt_rx_data[LANE1 +: LANE_W];
            out_data_q[LANE2 +: LANE_W] <= pkt_rx_data[LANE2 +: LANE_W];
            out_data_q[LANE3 +: LANE_W] <= pkt_rx_data[LANE3 +: LANE_W];
            out_data_q[LANE4 +: LANE_W] <= pkt_rx_data[LANE4 +: LANE_W];
            out_data_q[LANE5 +: LANE_W] <= pkt_rx_data[LANE5 +: LANE_W];
            out_data_q[LANE6 +: LANE_W] <= pkt_rx_data[LANE6 +: LANE_W];
            out_data_q[LANE7 +: LANE_W] <= pkt_rx_data[LANE7 +: LANE_W];

            // sop inside a packet, or a non-sop word outside one, breaks framing.
            if (pkt_rx_sop == in_pkt_q) begin
               proto_err_q <= 1'b1;
            end

            if (pkt_rx_eop) begin
               in_pkt_q        <= 1'b0;
               pkt_len_q       <= len_sum;
               pkt_len_valid_q <= 1'b1;
               rx_count_q      <= rx_count_q + 1'b1;
               if (pkt_rx_err) begin
                  err_count_q <= err_count_q + 1'b1;
               end
            end else if (pkt_rx_sop) begin
               in_pkt_q <= 1'b1;
            end
         end
      end
   end

   assign pkt_rx_ren    = ren_q;
   assign out_valid     = out_valid_q;
   assign out_sop       = out_sop_q;
   assign out_eop       = out_eop_q;
   assign out_mod       = out_mod_q;
   assign out_data      = out_data_q;
   assign pkt_len       = pkt_len_q;
   assign pkt_len_valid = pkt_len_valid_q;
   assign rx_count      = rx_count_q;
   assign err_count     = err_count_q;
   assign proto_err     = proto_err_q;
   assign all_done      = (rx_count_q == expected_count) && (expected_count != '0) &&
                          (state_q == ST_IDLE);

endmodule

// File: tb/tb_xge_pkt_rx_reader.sv
// Scoreboard bench for xge_pkt_rx_reader: stimulus pushes expected words/lengths, a monitor pops and compares.
module tb_xge_pkt_rx_reader;

   logic        clk;
   logic        rst_n;
   logic        avail;
   logic        val;
   logic        sop;
   logic        eop;
   logic [2:0]  mod;
   logic        err;
   logic [63:0] data;
   logic        ren;
   logic [31:0] exp_cnt;
   logic        out_valid;
   logic        out_sop;
   logic        out_eop;
   logic [2:0]  out_mod;
   logic [63:0] out_data;
   logic [15:0] pkt_len;
   logic        pkt_len_valid;
   logic [31:0] rx_count;
   logic [31:0] err_count;
   logic        proto_err;
   logic        all_done;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic [63:0] data;
   } fwd_t;

   fwd_t fwd_q[$];
   int   len_q[$];
   fwd_t mw;
   int   ml;
   int   n_chk  = 0;
   int   n_fail = 0;

   xge_pkt_rx_reader dut (
      .clk_156m25     (clk),
      .reset_156m25_n (rst_n),
      .pkt_rx_avail   (avail),
      .pkt_rx_val     (val),
      .pkt_rx_sop     (sop),
      .pkt_rx_eop     (eop),
      .pkt_rx_mod     (mod),
      .pkt_rx_err     (err),
      .pkt_rx_data    (data),
      .pkt_rx_ren     (ren),
      .expected_count (exp_cnt),
      .out_valid      (out_valid),
      .out_sop        (out_sop),
      .out_eop        (out_eop),
      .out_mod        (out_mod),
      .out_data       (out_data),
      .pkt_len        (pkt_len),
      .pkt_len_valid  (pkt_len_valid),
      .rx_count       (rx_count),
      .err_count      (err_count),
      .proto_err      (proto_err),
      .all_done       (all_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required end of test");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a word or a length.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (fwd_q.size() == 0) begin
               chk("fwd_unexpected", 64'(out_valid), 64'd0);
            end else begin
               mw = fwd_q.pop_front();
               chk("fwd_data", out_data, mw.data);
               chk("fwd_ctrl", 64'({out_sop, out_eop, out_mod}), 64'({mw.sop, mw.eop, mw.mod}));
            end
         end
         if (pkt_len_valid) begin
            if (len_q.size() == 0) begin
               chk("len_unexpected", 64'(pkt_len_valid), 64'd0);
            end else begin
               ml = len_q.pop_front();
               chk("pkt_len", 64'(pkt_len), 64'(ml));
            end
         end
      end
   end

   task automatic idle_cycle();
      val = 1'b0; sop = 1'b0; eop = 1'b0; mod = 3'd0; err = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic drive_word(input logic s, input logic e, input logic [2:0] m,
                             input logic er, input logic [63:0] d, input logic fwd);
      fwd_t w;
      val = 1'b1; sop = s; eop = e; mod = m; err = er; data = d;
      if (fwd) begin
         w.sop = s; w.eop = e; w.mod = m; w.data = d;
         fwd_q.push_back(w);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_ren();
      for (int k = 0; k < 32 && !ren; k++) begin
         @(posedge clk); #1;
      end
      chk("wait_ren", 64'(ren), 64'd1);
   endtask

   task automatic send_pkt(input int nw, input logic [2:0] m, input logic er,
                           input logic [63:0] base, input int exp_len);
      wait_ren();
      len_q.push_back(exp_len);
      for (int i = 0; i < nw; i++) begin
         drive_word(i == 0, i == nw - 1, (i == nw - 1) ? m : 3'd0,
                    (i == nw - 1) ? er : 1'b0, base + 64'(i), 1'b1);
      end
      val = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0;
      chk("ren_low_after_eop", 64'(ren), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; avail = 1'b0; val = 1'b0; sop = 1'b0; eop = 1'b0;
      mod = 3'd0; err = 1'b0; data = '0; exp_cnt = 32'd1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ren", 64'(ren), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_rx_count", 64'(rx_count), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      chk("rst_pkt_len", 64'(pkt_len), 64'd0);
      chk("rst_flags", 64'({pkt_len_valid, proto_err, all_done}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 64-byte packet; ren follows avail by one cycle.
      avail = 1'b1;
      chk("ren_before", 64'(ren), 64'd0);
      @(posedge clk); #1;
      chk("ren_after_avail", 64'(ren), 64'd1);
      send_pkt(8, 3'd0, 1'b0, 64'h0102_0304_0506_0700, 64);
      avail = 1'b0;
      chk("rx_count_p1", 64'(rx_count), 64'd1);
      chk("all_done_in_gap", 64'(all_done), 64'd0);
      idle_cycle();
      chk("all_done_p1", 64'(all_done), 64'd1);
      exp_cnt = 32'd9;
      #1;
      chk("all_done_cnt9", 64'(all_done), 64'd0);

      // 3-byte single word, then 69-byte packet.
      avail = 1'b1;
      send_pkt(1, 3'd3, 1'b0, 64'hAABB_CC00_0000_0000, 3);
      avail = 1'b0;
      idle_cycle(); idle_cycle();
      avail = 1'b1;
      send_pkt(9, 3'd5, 1'b0, 64'h1111_0000_0000_0000, 69);
      avail = 1'b0;
      chk("rx_count_p3", 64'(rx_count), 64'd3);
      idle_cycle(); idle_cycle();

      // Back-to-back with avail held high.
      avail = 1'b1;
      send_pkt(8, 3'd0, 1'b0, 64'h2222_0000_0000_0000, 64);
      idle_cycle();
      chk("ren_gap_idle", 64'(ren), 64'd0);
      send_pkt(2, 3'd0, 1'b0, 64'h3333_0000_0000_0000, 16);
      avail = 1'b0;
      chk("rx_count_b2b", 64'(rx_count), 64'd5);
      idle_cycle(); idle_cycle();

      // Error flagged on eop.
      avail = 1'b1;
      send_pkt(2, 3'd0, 1'b1, 64'h4444_0000_0000_0000, 16);
      avail = 1'b0;
      chk("err_count", 64'(err_count), 64'd1);
      chk("rx_count_err", 64'(rx_count), 64'd6);
      idle_cycle(); idle_cycle();

      // sop mid-packet restarts the length: 8+8+4 = 20.
      avail = 1'b1;
      wait_ren();
      len_q.push_back(20);
      drive_word(1'b1, 1'b0, 3'd0, 1'b0, 64'h5555_0000_0000_0001, 1'b1);
      drive_word(1'b0, 1'b0, 3'd0, 1'b0, 64'h5555_0000_0000_0002, 1'b1);
      drive_word(1'b1, 1'b0, 3'd0, 1'b0, 64'h5555_0000_0000_0003, 1'b1);
      chk("proto_err_mid_sop", 64'(proto_err), 64'd1);
      drive_word(1'b0, 1'b0, 3'd0, 1'b0, 64'h5555_0000_0000_0004, 1'b1);
      chk("proto_err_clear", 64'(proto_err), 64'd0);
      drive_word(1'b0, 1'b1, 3'd4, 1'b0, 64'h5555_0000_0000_0005, 1'b1);
      avail = 1'b0;
      chk("rx_count_mid_sop", 64'(rx_count), 64'd7);
      idle_cycle(); idle_cycle();

      // eop with no preceding sop: counted with the eop bytes only.
      avail = 1'b1;
      wait_ren();
      len_q.push_back(6);
      drive_word(1'b0, 1'b1, 3'd6, 1'b0, 64'h6666_0000_0000_0000, 1'b1);
      avail = 1'b0;
      chk("proto_err_orphan_eop", 64'(proto_err), 64'd1);
      chk("rx_count_orphan", 64'(rx_count), 64'd8);
      idle_cycle(); idle_cycle();

      // Valid word while IDLE is dropped and flagged.
      drive_word(1'b1, 1'b1, 3'd2, 1'b0, 64'h7777_0000_0000_0000, 1'b0);
      chk("proto_err_idle", 64'(proto_err), 64'd1);
      chk("rx_count_idle", 64'(rx_count), 64'd8);
      idle_cycle(); idle_cycle();

      // 8193 words = 65544 bytes saturates at 65535.
      avail = 1'b1;
      send_pkt(8193, 3'd0, 1'b0, 64'h8888_0000_0000_0000, 65535);
      avail = 1'b0;
      idle_cycle(); idle_cycle();
      chk("rx_count_sat", 64'(rx_count), 64'd9);
      chk("all_done_9", 64'(all_done), 64'd1);

      // Asynchronous reset mid-packet.
      avail = 1'b1;
      wait_ren();
      drive_word(1'b1, 1'b0, 3'd0, 1'b0, 64'h9999_0000_0000_0001, 1'b1);
      drive_word(1'b0, 1'b0, 3'd0, 1'b0, 64'h9999_0000_0000_0002, 1'b1);
      idle_cycle();
      #2;
      rst_n = 1'b0;
      avail = 1'b0;
      #1;
      chk("mid_rst_ren", 64'(ren), 64'd0);
      chk("mid_rst_counts", 64'({rx_count, err_count}), 64'd0);
      chk("mid_rst_out", out_data, 64'd0);
      chk("mid_rst_flags", 64'({out_valid, out_sop, out_eop, out_mod, all_done}), 64'd0);
      chk("mid_rst_len", 64'(pkt_len), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_cnt = 32'd1;
      @(posedge clk); #1;
      avail = 1'b1;
      send_pkt(8, 3'd0, 1'b0, 64'hA0A0_0000_0000_0000, 64);
      avail = 1'b0;
      chk("rx_count_after_rst", 64'(rx_count), 64'd1);
      idle_cycle(); idle_cycle();
      chk("all_done_after_rst", 64'(all_done), 64'd1);

      chk("fwd_queue_empty", 64'(fwd_q.size()), 64'd0);
      chk("len_queue_empty", 64'(len_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
